// File: rtl/instr_sequencer.sv
// instr_sequencer: microcode sequencer producing the state word for the control decoder.
// Every instruction starts with FETCH_PC -> FETCH_INST. At the FETCH_INST edge the opcode
// is latched from the top nibble of the data bus. The sequencer then walks a fixed
// per-opcode list of micro-states and returns to FETCH_PC.
// A fetch/execute phase bit and a 3-bit step index tell the instruction-fetch FETCH_PC
// apart from the operand-fetch FETCH_PC used inside LDI, LD, ST, JMP and CALL.
module instr_sequencer #(
  parameter int CNT_WIDTH   = 16,
  parameter int STATE_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   run,
  input  logic [7:0]             bus_data,
  output logic [STATE_WIDTH-1:0] state,
  output logic [3:0]             opcode,
  output logic                   instr_done,
  output logic                   halted,
  output logic [CNT_WIDTH-1:0]   instr_count
);

  // Micro-state codes shared with the control decoder
  typedef enum logic [7:0] {
    STATE_FETCH_PC   = 8'h00,
    STATE_FETCH_INST = 8'h01,
    STATE_LOAD_ADDR  = 8'h02,
    STATE_SET_REG    = 8'h03,
    STATE_SET_MEM    = 8'h04,
    STATE_ALU_EXEC   = 8'h05,
    STATE_ALU_OUT    = 8'h06,
    STATE_MOV_REG    = 8'h07,
    STATE_JUMP       = 8'h08,
    STATE_FETCH_SP   = 8'h09,
    STATE_STACK_REG  = 8'h0A,
    STATE_STORE_PC   = 8'h0B,
    STATE_TMP_JUMP   = 8'h0C,
    STATE_INC_SP     = 8'h0D,
    STATE_RET        = 8'h0E,
    STATE_SET_MAR    = 8'h0F,
    STATE_HALT       = 8'hFF
  } state_e;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ALU  = 4'h1;
  localparam logic [3:0] OP_MOV  = 4'h2;
  localparam logic [3:0] OP_LDI  = 4'h3;
  localparam logic [3:0] OP_LD   = 4'h4;
  localparam logic [3:0] OP_ST   = 4'h5;
  localparam logic [3:0] OP_JMP  = 4'h6;
  localparam logic [3:0] OP_PUSH = 4'h7;
  localparam logic [3:0] OP_CALL = 4'h8;
  localparam logic [3:0] OP_RET  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // Micro-state issued at position idx of an opcode's execute list
  function automatic state_e ucode_state(input logic [3:0] op, input logic [2:0] idx);
    state_e s;
    s = STATE_FETCH_PC;
    case (op)
      OP_ALU: begin
        case (idx)
          3'd0:    s = STATE_ALU_EXEC;
          default: s = STATE_ALU_OUT;
        endcase
      end
      OP_MOV: s = STATE_MOV_REG;
      OP_LDI: begin
        case (idx)
          3'd0:    s = STATE_FETCH_PC;
          default: s = STATE_SET_REG;
        endcase
      end
      OP_LD: begin
        case (idx)
          3'd0:    s = STATE_FETCH_PC;
          3'd1:    s = STATE_LOAD_ADDR;
          default: s = STATE_SET_REG;
        endcase
      end
      OP_ST: begin
        case (idx)
          3'd0:    s = STATE_FETCH_PC;
          3'd1:    s = STATE_LOAD_ADDR;
          default: s = STATE_SET_MEM;
        endcase
      end
      OP_JMP: begin
        case (idx)
          3'd0:    s = STATE_FETCH_PC;
          default: s = STATE_JUMP;
        endcase
      end
      OP_PUSH: begin
        case (idx)
          3'd0:    s = STATE_FETCH_SP;
          default: s = STATE_STACK_REG;
        endcase
      end
      OP_CALL: begin
        case (idx)
          3'd0:    s = STATE_FETCH_PC;
          3'd1:    s = STATE_FETCH_SP;
          3'd2:    s = STATE_STORE_PC;
          default: s = STATE_TMP_JUMP;
        endcase
      end
      OP_RET: begin
        case (idx)
          3'd0:    s = STATE_INC_SP;
          3'd1:    s = STATE_FETCH_SP;
          default: s = STATE_RET;
        endcase
      end
      default: s = STATE_FETCH_PC;
    endcase
    return s;
  endfunction

  // Index of the final step in an opcode's execute list
  function automatic logic [2:0] ucode_last(input logic [3:0] op);
    logic [2:0] last;
    last = 3'd0;
    case (op)
      OP_ALU:  last = 3'd1;
      OP_MOV:  last = 3'd0;
      OP_LDI:  last = 3'd1;
      OP_LD:   last = 3'd2;
      OP_ST:   last = 3'd2;
      OP_JMP:  last = 3'd1;
      OP_PUSH: last = 3'd1;
      OP_CALL: last = 3'd3;
      OP_RET:  last = 3'd2;
      default: last = 3'd0;
    endcase
    return last;
  endfunction

  // True for opcodes with at least one execute step; NOP and 0xA-0xE have none
  function automatic logic has_body(input logic [3:0] op);
    return (op >= OP_ALU) && (op <= OP_RET);
  endfunction

  state_e               state_q, state_d;
  logic [2:0]           step_q, step_d;
  logic                 exec_q, exec_d;
  logic [3:0]           opcode_q, opcode_d;
  logic                 instr_done_q, instr_done_d;
  logic                 halted_q, halted_d;
  logic [CNT_WIDTH-1:0] instr_count_q, instr_count_d;

  logic [3:0] fetched_op;
  logic       unused_bus_low;

  assign fetched_op     = bus_data[7:4];
  assign unused_bus_low = ^bus_data[3:0];

  // Next-state sequencing: fetch phase, opcode latch, execute-list walk, retire and halt
  always_comb begin
    state_d       = state_q;
    step_d        = step_q;
    exec_d        = exec_q;
    opcode_d      = opcode_q;
    instr_done_d  = 1'b0;
    halted_d      = halted_q;
    instr_count_d = instr_count_q;

    if (state_q == STATE_HALT) begin
      halted_d = 1'b1;
    end else if (run) begin
      if (!exec_q) begin
        if (state_q == STATE_FETCH_INST) begin
          opcode_d = fetched_op;
          step_d   = 3'd0;
          if (fetched_op == OP_HALT) begin
            state_d  = STATE_HALT;
            halted_d = 1'b1;
          end else if (has_body(fetched_op)) begin
            state_d = ucode_state(fetched_op, 3'd0);
            exec_d  = 1'b1;
          end else begin
            state_d       = STATE_FETCH_PC;
            instr_done_d  = 1'b1;
            instr_count_d = instr_count_q + CNT_ONE;
          end
        end else begin
          state_d = STATE_FETCH_INST;
        end
      end else if (step_q == ucode_last(opcode_q)) begin
        state_d       = STATE_FETCH_PC;
        exec_d        = 1'b0;
        step_d        = 3'd0;
        instr_done_d  = 1'b1;
        instr_count_d = instr_count_q + CNT_ONE;
      end else begin
        step_d  = step_q + 3'd1;
        state_d = ucode_state(opcode_q, step_q + 3'd1);
      end
    end
  end

  // Sequencer registers with asynchronous return to the fetch state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= STATE_FETCH_PC;
      step_q        <= 3'd0;
      exec_q        <= 1'b0;
      opcode_q      <= OP_NOP;
      instr_done_q  <= 1'b0;
      halted_q      <= 1'b0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      step_q        <= step_d;
      exec_q        <= exec_d;
      opcode_q      <= opcode_d;
      instr_done_q  <= instr_done_d;
      halted_q      <= halted_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign state       = STATE_WIDTH'(state_q);
  assign opcode      = opcode_q;
  assign instr_done  = instr_done_q;
  assign halted      = halted_q;
  assign instr_count = instr_count_q;

  // The retire pulse only ever appears in an instruction-fetch FETCH_PC cycle
  a_done_in_fetch: assert property (@(posedge clk) disable iff (!rst_n)
    instr_done_q |-> (state_q == STATE_FETCH_PC && !exec_q));

  // The halt flag tracks the HALT state exactly
  a_halt_flag: assert property (@(posedge clk) disable iff (!rst_n)
    halted_q == (state_q == STATE_HALT));

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: scoreboard bench for instr_sequencer (4-bit counter build).
module tb_instr_sequencer;

  localparam logic [7:0] S_FETCH_PC   = 8'h00;
  localparam logic [7:0] S_FETCH_INST = 8'h01;
  localparam logic [7:0] S_LOAD_ADDR  = 8'h02;
  localparam logic [7:0] S_SET_REG    = 8'h03;
  localparam logic [7:0] S_SET_MEM    = 8'h04;
  localparam logic [7:0] S_ALU_EXEC   = 8'h05;
  localparam logic [7:0] S_ALU_OUT    = 8'h06;
  localparam logic [7:0] S_MOV_REG    = 8'h07;
  localparam logic [7:0] S_JUMP       = 8'h08;
  localparam logic [7:0] S_FETCH_SP   = 8'h09;
  localparam logic [7:0] S_STACK_REG  = 8'h0A;
  localparam logic [7:0] S_STORE_PC   = 8'h0B;
  localparam logic [7:0] S_TMP_JUMP   = 8'h0C;
  localparam logic [7:0] S_INC_SP     = 8'h0D;
  localparam logic [7:0] S_RET        = 8'h0E;
  localparam logic [7:0] S_HALT       = 8'hFF;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic [7:0] bus_data;
  logic [7:0] state;
  logic [3:0] opcode;
  logic       instr_done;
  logic       halted;
  logic [3:0] instr_count;

  instr_sequencer #(.CNT_WIDTH(4), .STATE_WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .bus_data    (bus_data),
    .state       (state),
    .opcode      (opcode),
    .instr_done  (instr_done),
    .halted      (halted),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] st;
    logic       done;
    logic [3:0] cnt;
    logic [3:0] op;
    logic       halt;
    logic       drv_run;
    logic [7:0] drv_bus;
    bit         abort;
  } sb_t;

  sb_t sb_q[$];

  int checks = 0;
  int errors = 0;

  logic [3:0] m_count;
  logic       m_done_pending;
  logic [3:0] m_opcode;

  // Execute-list of each opcode, packed first step in the top byte
  function automatic logic [31:0] body_list(input logic [3:0] op);
    case (op)
      4'h1: return {S_ALU_EXEC, S_ALU_OUT, 16'h0};
      4'h2: return {S_MOV_REG, 24'h0};
      4'h3: return {S_FETCH_PC, S_SET_REG, 16'h0};
      4'h4: return {S_FETCH_PC, S_LOAD_ADDR, S_SET_REG, 8'h0};
      4'h5: return {S_FETCH_PC, S_LOAD_ADDR, S_SET_MEM, 8'h0};
      4'h6: return {S_FETCH_PC, S_JUMP, 16'h0};
      4'h7: return {S_FETCH_SP, S_STACK_REG, 16'h0};
      4'h8: return {S_FETCH_PC, S_FETCH_SP, S_STORE_PC, S_TMP_JUMP};
      4'h9: return {S_INC_SP, S_FETCH_SP, S_RET, 8'h0};
      default: return 32'h0;
    endcase
  endfunction

  // Total cycles per instruction including the two fetch cycles
  function automatic int cpi(input logic [3:0] op);
    case (op)
      4'h1, 4'h3, 4'h6, 4'h7: return 4;
      4'h2: return 3;
      4'h4, 4'h5, 4'h9: return 5;
      4'h8: return 6;
      default: return 2;
    endcase
  endfunction

  function automatic logic [7:0] body_state(input logic [3:0] op, input int idx);
    logic [31:0] l;
    l = body_list(op);
    return l[31-8*idx -: 8];
  endfunction

  task automatic model_reset();
    m_count        = 4'd0;
    m_done_pending = 1'b0;
    m_opcode       = 4'h0;
  endtask

  // Runs one instruction: queue expected per-cycle outputs, then pop and compare each cycle
  task automatic run_instr(input string tag, input logic [3:0] op, input logic [7:0] noise,
                           input int stall_at, input int stall_len, input int abort_at);
    sb_t e;
    int  n;
    int  reps;
    bit  is_halt;
    is_halt = (op == 4'hF);
    n = is_halt ? 10 : cpi(op);
    for (int i = 0; i < n; i++) begin
      reps = (i == stall_at) ? stall_len + 1 : 1;
      for (int k = 0; k < reps; k++) begin
        if (i == 0)      e.st = S_FETCH_PC;
        else if (i == 1) e.st = S_FETCH_INST;
        else if (is_halt) e.st = S_HALT;
        else             e.st = body_state(op, i - 2);
        e.done    = (i == 0 && k == 0) ? m_done_pending : 1'b0;
        e.cnt     = m_count;
        e.op      = (i < 2) ? m_opcode : op;
        e.halt    = is_halt && (i >= 2);
        e.drv_run = (k < reps - 1) ? 1'b0 : 1'b1;
        e.drv_bus = (i == 1) ? {op, noise[3:0]} : noise;
        if (is_halt && i >= 2) begin
          e.drv_run = 1'($urandom_range(0, 1));
          e.drv_bus = 8'($urandom);
        end
        e.abort = (i == abort_at);
        sb_q.push_back(e);
      end
      if (i == abort_at) break;
    end
    m_done_pending = 1'b0;

    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if (state !== e.st) begin
        errors++;
        $display("[TB] FAIL %s state: got %h want %h", tag, state, e.st);
      end
      checks++;
      if (instr_done !== e.done) begin
        errors++;
        $display("[TB] FAIL %s instr_done: got %b want %b", tag, instr_done, e.done);
      end
      checks++;
      if (instr_count !== e.cnt) begin
        errors++;
        $display("[TB] FAIL %s instr_count: got %0d want %0d", tag, instr_count, e.cnt);
      end
      checks++;
      if (opcode !== e.op) begin
        errors++;
        $display("[TB] FAIL %s opcode: got %h want %h", tag, opcode, e.op);
      end
      checks++;
      if (halted !== e.halt) begin
        errors++;
        $display("[TB] FAIL %s halted: got %b want %b", tag, halted, e.halt);
      end
      if (e.abort) begin
        rst_n = 1'b0;
        #1;
        checks++;
        if (state !== S_FETCH_PC) begin
          errors++;
          $display("[TB] FAIL %s abort state: got %h want %h", tag, state, S_FETCH_PC);
        end
        checks++;
        if (instr_count !== 4'd0) begin
          errors++;
          $display("[TB] FAIL %s abort instr_count: got %0d want 0", tag, instr_count);
        end
        checks++;
        if (opcode !== 4'h0) begin
          errors++;
          $display("[TB] FAIL %s abort opcode: got %h want 0", tag, opcode);
        end
        sb_q.delete();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        run   = 1'b1;
        return;
      end
      run      = e.drv_run;
      bus_data = e.drv_bus;
      @(negedge clk);
    end

    if (!is_halt) begin
      m_count        = m_count + 4'd1;
      m_done_pending = 1'b1;
      m_opcode       = op;
    end
  endtask

  task automatic test_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (state !== S_FETCH_PC) begin
      errors++;
      $display("[TB] FAIL %s state: got %h want %h", tag, state, S_FETCH_PC);
    end
    checks++;
    if (instr_count !== 4'd0) begin
      errors++;
      $display("[TB] FAIL %s instr_count: got %0d want 0", tag, instr_count);
    end
    checks++;
    if (halted !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s halted: got %b want 0", tag, halted);
    end
    checks++;
    if (instr_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s instr_done: got %b want 0", tag, instr_done);
    end
    checks++;
    if (opcode !== 4'h0) begin
      errors++;
      $display("[TB] FAIL %s opcode: got %h want 0", tag, opcode);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (state !== S_FETCH_PC) begin
      errors++;
      $display("[TB] FAIL %s held state: got %h want %h", tag, state, S_FETCH_PC);
    end
    rst_n = 1'b1;
    run   = 1'b1;
    model_reset();
  endtask

  task automatic test_nop();
    run_instr("nop", 4'h0, 8'h00, -1, 0, -1);
    run_instr("mov_after_nop", 4'h2, 8'h5A, -1, 0, -1);
  endtask

  task automatic test_call();
    run_instr("call", 4'h8, 8'hC7, -1, 0, -1);
  endtask

  task automatic test_operand_noise();
    run_instr("ld_noise", 4'h4, 8'hF3, -1, 0, -1);
    run_instr("ldi_noise", 4'h3, 8'hF0, -1, 0, -1);
  endtask

  task automatic test_back_to_back();
    logic [3:0] ops[12];
    ops = '{4'h1, 4'h3, 4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'h2};
    for (int i = 0; i < 12; i++) begin
      run_instr("b2b", ops[i], 8'($urandom), -1, 0, -1);
    end
  endtask

  task automatic test_stall();
    run_instr("alu_stall", 4'h1, 8'h96, 2, 3, -1);
    run_instr("call_stall", 4'h8, 8'h21, 4, 2, -1);
  endtask

  task automatic test_halt();
    run_instr("halt", 4'hF, 8'h44, -1, 0, -1);
    test_reset("halt_reset");
    run_instr("after_halt", 4'h0, 8'h00, -1, 0, -1);
  endtask

  task automatic test_wrap();
    test_reset("wrap_reset");
    for (int i = 0; i < 16; i++) begin
      run_instr("wrap", 4'h0, 8'h0C, -1, 0, -1);
    end
    checks++;
    if (instr_count !== 4'd0) begin
      errors++;
      $display("[TB] FAIL wrap_zero instr_count: got %0d want 0", instr_count);
    end
    run_instr("wrap_next", 4'h2, 8'h33, -1, 0, -1);
  endtask

  task automatic test_abort();
    run_instr("pre_abort", 4'h0, 8'h00, -1, 0, -1);
    run_instr("pre_abort", 4'h0, 8'h00, -1, 0, -1);
    run_instr("st_abort", 4'h5, 8'h6E, -1, 0, 3);
    run_instr("post_abort", 4'h0, 8'h00, -1, 0, -1);
    run_instr("post_abort2", 4'h2, 8'h11, -1, 0, -1);
  endtask

  initial begin
    rst_n    = 1'b0;
    run      = 1'b1;
    bus_data = 8'h00;
    model_reset();
    test_reset("reset");
    test_nop();
    test_call();
    test_operand_noise();
    test_back_to_back();
    test_stall();
    test_halt();
    test_wrap();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
